// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and its surroundings: the switch/strobe entry,
// the shared ALU operand/opcode lines, the ALU result, and the captured-result
// display path. The slave side is the sequencer. The master side is whatever
// drives the switches and hosts the ALU.
interface alu_sequencer_if;
  logic [7:0] data_in;
  logic       load;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [7:0] result;
  logic       carry;
  logic       result_valid;
  logic       busy;
  logic [2:0] state;

  modport master (
    output data_in, load, alu_result, alu_carry,
    input  alu_a, alu_b, alu_op, result, carry, result_valid, busy, state
  );

  modport slave (
    input  data_in, load, alu_result, alu_carry,
    output alu_a, alu_b, alu_op, result, carry, result_valid, busy, state
  );
endinterface

// File: rtl/alu_sequencer.sv
// Front-end controller for the shared 8-bit ALU. It collects an opcode byte and
// operand bytes, one per rising edge of the load strobe. It holds them on the
// ALU inputs for ALU_LATENCY cycles, then captures result and carry. Chain mode
// (opcode bit 3) reuses the last captured result as operand A and skips the
// operand-A entry step.
module alu_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GET_A = 3'd1;
  localparam logic [2:0] GET_B = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Out-of-range latencies are pinned to the nearest legal value. This keeps the
  // 4-bit counter from wrapping and avoids an EXEC state that never ends.
  localparam int         LAT_CLAMPED = (ALU_LATENCY < 1)  ? 1  :
                                       (ALU_LATENCY > 15) ? 15 : ALU_LATENCY;
  localparam logic [3:0] LAT_LOAD    = LAT_CLAMPED[3:0];

  logic [2:0] state_reg, state_next;
  logic       load_q_reg;
  logic [7:0] alu_a_reg, alu_a_next;
  logic [7:0] alu_b_reg, alu_b_next;
  logic [2:0] alu_op_reg, alu_op_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] result_reg, result_next;
  logic       carry_reg, carry_next;
  logic       result_valid_reg;
  logic       busy_reg;
  logic       accept;

  // A load is accepted only on its rising edge. A level held high is a single entry.
  assign accept = bus.load & ~load_q_reg;

  // Next-state and register-update decisions for the entry/execute sequence.
  always_comb begin
    state_next  = state_reg;
    alu_a_next  = alu_a_reg;
    alu_b_next  = alu_b_reg;
    alu_op_next = alu_op_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          alu_op_next = bus.data_in[2:0];
          if (bus.data_in[3]) begin
            // Chain: the previous result becomes operand A directly.
            alu_a_next = result_reg;
            state_next = GET_B;
          end else begin
            state_next = GET_A;
          end
        end
      end
      GET_A: begin
        if (accept) begin
          alu_a_next = bus.data_in;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (accept) begin
          alu_b_next = bus.data_in;
          cnt_next   = LAT_LOAD;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // The last counted cycle is the capture point. Loads are ignored throughout.
        if (cnt_reg <= 4'd1) begin
          result_next = bus.alu_result;
          carry_next  = bus.alu_carry;
          cnt_next    = 4'd0;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, operand, counter and result registers. Status outputs are decoded
  // from the next state, so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      load_q_reg       <= 1'b1;
      alu_a_reg        <= 8'd0;
      alu_b_reg        <= 8'd0;
      alu_op_reg       <= 3'd0;
      cnt_reg          <= 4'd0;
      result_reg       <= 8'd0;
      carry_reg        <= 1'b0;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      load_q_reg       <= bus.load;
      alu_a_reg        <= alu_a_next;
      alu_b_reg        <= alu_b_next;
      alu_op_reg       <= alu_op_next;
      cnt_reg          <= cnt_next;
      result_reg       <= result_next;
      carry_reg        <= carry_next;
      result_valid_reg <= (state_next == DONE);
      busy_reg         <= (state_next == EXEC) || (state_next == DONE);
    end
  end

  assign bus.alu_a        = alu_a_reg;
  assign bus.alu_b        = alu_b_reg;
  assign bus.alu_op       = alu_op_reg;
  assign bus.result       = result_reg;
  assign bus.carry        = carry_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.busy         = busy_reg;
  assign bus.state        = state_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. It runs three instances with latencies 1, 4
// and 8. They share the switch byte and clock, and each has its own load strobe,
// reset and ALU model. Inputs change and outputs are sampled on the falling edge.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic [7:0] data_in;
  logic [2:0] load_v;
  logic [2:0] rst_v;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // Bench ALU: 0 add, 1 subtract (bit 8 = borrow), 2 and, 3 or, 4 xor, else pass A.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  alu_sequencer_if if1 ();
  alu_sequencer_if if4 ();
  alu_sequencer_if if8 ();

  assign if1.data_in = data_in;
  assign if4.data_in = data_in;
  assign if8.data_in = data_in;
  assign if1.load    = load_v[0];
  assign if4.load    = load_v[1];
  assign if8.load    = load_v[2];
  assign {if1.alu_carry, if1.alu_result} = alu_f(if1.alu_op, if1.alu_a, if1.alu_b);
  assign {if4.alu_carry, if4.alu_result} = alu_f(if4.alu_op, if4.alu_a, if4.alu_b);
  assign {if8.alu_carry, if8.alu_result} = alu_f(if8.alu_op, if8.alu_a, if8.alu_b);

  alu_sequencer #(.ALU_LATENCY(1)) u1 (.clk(clk), .reset(rst_v[0]), .bus(if1));
  alu_sequencer #(.ALU_LATENCY(4)) u4 (.clk(clk), .reset(rst_v[1]), .bus(if4));
  alu_sequencer #(.ALU_LATENCY(8)) u8 (.clk(clk), .reset(rst_v[2]), .bus(if8));

  logic [2:0] st [3];
  logic [7:0] av [3], bv [3], res [3];
  logic [2:0] op [3];
  logic       cy [3], rv [3], bz [3];

  assign st[0] = if1.state;  assign st[1] = if4.state;  assign st[2] = if8.state;
  assign av[0] = if1.alu_a;  assign av[1] = if4.alu_a;  assign av[2] = if8.alu_a;
  assign bv[0] = if1.alu_b;  assign bv[1] = if4.alu_b;  assign bv[2] = if8.alu_b;
  assign op[0] = if1.alu_op; assign op[1] = if4.alu_op; assign op[2] = if8.alu_op;
  assign res[0] = if1.result; assign res[1] = if4.result; assign res[2] = if8.result;
  assign cy[0] = if1.carry;  assign cy[1] = if4.carry;  assign cy[2] = if8.carry;
  assign rv[0] = if1.result_valid; assign rv[1] = if4.result_valid;
  assign rv[2] = if8.result_valid;
  assign bz[0] = if1.busy;   assign bz[1] = if4.busy;   assign bz[2] = if8.busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One entry: strobe high for one cycle, then low for one cycle.
  task automatic pulse(input int idx, input logic [7:0] val);
    data_in     = val;
    load_v[idx] = 1'b1;
    @(negedge clk);
    load_v[idx] = 1'b0;
    @(negedge clk);
  endtask

  // Wait (bounded) for result_valid on one instance.
  task automatic wait_rv(input int idx, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rv[idx]) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  int busy_cnt;

  initial begin
    data_in = 8'h00;
    load_v  = 3'b111;
    rst_v   = 3'b111;

    // Reset with load held high.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_state%0d", i), {29'd0, st[i]}, 32'd0);
      chk($sformatf("rst_out%0d", i),
          {av[i], bv[i], res[i], op[i], cy[i], rv[i], bz[i], 2'b00}, 32'd0);
    end
    rst_v = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("held_after_rst%0d", i), {29'd0, st[0]}, 32'd0);
    end
    load_v = 3'b000;
    @(negedge clk);

    // Basic add, latency 1: 0x7F + 0x81 = 0x100.
    pulse(0, 8'h00);
    chk("add_getA", {29'd0, st[0]}, 32'd1);
    pulse(0, 8'h7F);
    chk("add_getB", {29'd0, st[0]}, 32'd2);
    chk("add_a", {24'd0, av[0]}, 32'h7F);
    data_in = 8'h81; load_v[0] = 1'b1;
    @(negedge clk);
    chk("add_exec", {29'd0, st[0]}, 32'd3);
    chk("add_b", {24'd0, bv[0]}, 32'h81);
    chk("add_rv_early", {31'd0, rv[0]}, 32'd0);
    load_v[0] = 1'b0;
    @(negedge clk);
    chk("add_done", {29'd0, st[0]}, 32'd4);
    chk("add_res", {23'd0, cy[0], res[0]}, 32'h100);
    chk("add_rv", {30'd0, rv[0], bz[0]}, 32'd3);
    @(negedge clk);
    chk("add_idle", {29'd0, st[0]}, 32'd0);
    chk("add_rv_off", {30'd0, rv[0], bz[0]}, 32'd0);
    chk("add_res_hold", {23'd0, cy[0], res[0]}, 32'h100);

    // AND, latency 1: 0xF0 & 0x3C = 0x30.
    pulse(0, 8'h02);
    pulse(0, 8'hF0);
    pulse(0, 8'h3C);
    chk("and_done", {29'd0, st[0]}, 32'd4);
    chk("and_op", {29'd0, op[0]}, 32'd2);
    chk("and_res", {23'd0, cy[0], res[0]}, 32'h030);

    // Held load: 10 cycles high gives one advance. Then subtract 0x20 - 0x05.
    @(negedge clk);
    data_in = 8'h01; load_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_one_step", {29'd0, st[0]}, 32'd1);
    load_v[0] = 1'b0;
    @(negedge clk);
    pulse(0, 8'h20);
    chk("sub_a", {24'd0, av[0]}, 32'h20);
    pulse(0, 8'h05);
    chk("sub_done", {29'd0, st[0]}, 32'd4);
    chk("sub_res", {23'd0, cy[0], res[0]}, 32'h01B);

    // Latency 4: 0x10 + 0x05. result appears 4 edges after the accepting edge.
    pulse(1, 8'h00);
    pulse(1, 8'h10);
    data_in = 8'h05; load_v[1] = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_v[1] = 1'b0;
      if (bz[1]) busy_cnt++;
      if (i < 4) begin
        chk($sformatf("lat_exec%0d", i), {29'd0, st[1]}, 32'd3);
        chk($sformatf("lat_ops%0d", i), {5'd0, op[1], av[1], bv[1], 8'd0}, 32'h00100500);
        chk($sformatf("lat_res_old%0d", i), {24'd0, res[1]}, 32'h00);
      end
      if (i == 4) begin
        chk("lat_res", {23'd0, cy[1], res[1]}, 32'h015);
        chk("lat_rv", {31'd0, rv[1]}, 32'd1);
      end
    end
    chk("lat_busy_cycles", busy_cnt, 32'd5);
    chk("lat_idle", {29'd0, st[1]}, 32'd0);

    // Chain: A comes from previous result 0x15, plus 0x01.
    pulse(1, 8'h08);
    chk("chain_skip", {29'd0, st[1]}, 32'd2);
    chk("chain_a", {24'd0, av[1]}, 32'h15);
    pulse(1, 8'h01);
    wait_rv(1, "chain_timeout");
    chk("chain_res", {23'd0, cy[1], res[1]}, 32'h016);
    @(negedge clk);

    // Loads during EXEC and DONE are ignored: OR 0x0F | 0x30.
    pulse(1, 8'h03);
    pulse(1, 8'h0F);
    data_in = 8'h30; load_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    @(negedge clk);
    data_in = 8'hAA; load_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    chk("ign_exec_state", {29'd0, st[1]}, 32'd3);
    chk("ign_exec_regs", {5'd0, op[1], av[1], bv[1], 8'd0}, 32'h030F3000);
    @(negedge clk);
    @(negedge clk);
    chk("ign_done_state", {29'd0, st[1]}, 32'd4);
    data_in = 8'h55; load_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    chk("ign_done_idle", {29'd0, st[1]}, 32'd0);
    chk("ign_done_regs", {5'd0, op[1], av[1], bv[1], 8'd0}, 32'h030F3000);
    chk("ign_res", {23'd0, cy[1], res[1]}, 32'h03F);
    @(negedge clk);
    chk("ign_still_idle", {29'd0, st[1]}, 32'd0);
    pulse(1, 8'h04);
    chk("next_getA", {29'd0, st[1]}, 32'd1);
    pulse(1, 8'hFF);
    pulse(1, 8'h0F);
    wait_rv(1, "next_timeout");
    chk("next_res", {23'd0, cy[1], res[1]}, 32'h0F0);

    // Chain straight after reset uses A = 0, then reset mid-EXEC (latency 8).
    pulse(2, 8'h08);
    chk("rchain_state", {29'd0, st[2]}, 32'd2);
    chk("rchain_a", {24'd0, av[2]}, 32'h00);
    pulse(2, 8'h33);
    chk("mid_exec", {29'd0, st[2]}, 32'd3);
    rst_v[2] = 1'b1;
    @(negedge clk);
    rst_v[2] = 1'b0;
    chk("mid_rst_state", {29'd0, st[2]}, 32'd0);
    chk("mid_rst_regs", {av[2], bv[2], res[2], op[2], cy[2], rv[2], bz[2], 2'b00}, 32'd0);
    begin
      logic rv_seen;
      rv_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (rv[2]) rv_seen = 1'b1;
      end
      chk("mid_no_rv", {31'd0, rv_seen}, 32'd0);
      chk("mid_res_zero", {23'd0, cy[2], res[2]}, 32'd0);
      chk("mid_idle", {29'd0, st[2]}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
